// File: rtl/counter_seq_pkg.sv
// Shared widths and state encoding for the counter sequencer slice.
package counter_seq_pkg;

    localparam int unsigned NBITS_COUNT = 4;
    localparam int unsigned NBITS_DWELL = 3;
    localparam int unsigned NBITS_REP   = 2;
    localparam int unsigned NBITS_STATE = 3;

    typedef enum logic [NBITS_STATE-1:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_UP       = 3'd2,
        ST_DWELL_HI = 3'd3,
        ST_DOWN     = 3'd4,
        ST_DWELL_LO = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

endpackage

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between the board top level, the sequencer and the external counter.
interface counter_sequencer_if;

    logic                                       start;
    logic                                       abort;
    logic                                       pause;
    logic [counter_seq_pkg::NBITS_COUNT-1:0]    lo;
    logic [counter_seq_pkg::NBITS_COUNT-1:0]    hi;
    logic [counter_seq_pkg::NBITS_DWELL-1:0]    dwell;
    logic [counter_seq_pkg::NBITS_REP-1:0]      reps;
    logic [counter_seq_pkg::NBITS_COUNT-1:0]    count;
    logic                                       ctr_load;
    logic [counter_seq_pkg::NBITS_COUNT-1:0]    ctr_data;
    logic                                       ctr_en;
    logic                                       ctr_up;
    logic                                       busy;
    logic                                       done;
    logic                                       err;
    logic [counter_seq_pkg::NBITS_STATE-1:0]    state;

    modport master (
        output start, abort, pause, lo, hi, dwell, reps, count,
        input  ctr_load, ctr_data, ctr_en, ctr_up, busy, done, err, state
    );

    modport slave (
        input  start, abort, pause, lo, hi, dwell, reps, count,
        output ctr_load, ctr_data, ctr_en, ctr_up, busy, done, err, state
    );

endinterface

// File: rtl/counter_sequencer_dwell_timer.sv
// Down-counting dwell timer: load, decrement and a zero flag.
module dwell_timer
    import counter_seq_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [NBITS_DWELL-1:0] load_val_i,
    input  logic                   dec_i,
    output logic                   zero_c_o
);

    logic [NBITS_DWELL-1:0] timer_q;
    logic [NBITS_DWELL-1:0] timer_d;

    always_comb begin
        timer_d = timer_q;
        if (load_i) begin
            timer_d = load_val_i;
        end else if (dec_i && (timer_q != '0)) begin
            timer_d = timer_q - NBITS_DWELL'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign zero_c_o = (timer_q == '0);

endmodule

// File: rtl/counter_sequencer.sv
// Runs the external up/down counter lo->hi, dwell, hi->lo, dwell for reps+1 passes.
module counter_sequencer
    import counter_seq_pkg::*;
(
    input  logic               clk_2,
    input  logic               reset,
    counter_sequencer_if.slave bus
);

    state_e                 state_q, state_d;
    logic                   start_q;
    logic                   err_q, err_d;
    logic [NBITS_COUNT-1:0] lo_q, hi_q;
    logic [NBITS_DWELL-1:0] dwell_q;
    logic [NBITS_REP-1:0]   reps_q;
    logic [NBITS_REP-1:0]   pass_q, pass_d;

    logic latch_cfg;
    logic tmr_load;
    logic tmr_dec;
    logic tmr_zero;
    logic start_edge;
    logic at_hi;
    logic at_lo;
    logic ctr_load_c;
    logic ctr_en_c;
    logic ctr_up_c;

    dwell_timer u_dwell_timer (
        .clk_i      (clk_2),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (dwell_q),
        .dec_i      (tmr_dec),
        .zero_c_o   (tmr_zero)
    );

    assign start_edge = bus.start && !start_q;
    assign at_hi      = (bus.count == hi_q);
    assign at_lo      = (bus.count == lo_q);

    // Next state and counter controls; abort overrides everything at the end.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        pass_d     = pass_q;
        latch_cfg  = 1'b0;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        ctr_load_c = 1'b0;
        ctr_en_c   = 1'b0;
        ctr_up_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    if (bus.lo > bus.hi) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        latch_cfg = 1'b1;
                        err_d     = 1'b0;
                        pass_d    = '0;
                        state_d   = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                ctr_load_c = 1'b1;
                if (!bus.pause) state_d = ST_UP;
            end
            ST_UP: begin
                ctr_up_c = 1'b1;
                ctr_en_c = !at_hi && !bus.pause;
                if (at_hi && !bus.pause) begin
                    tmr_load = 1'b1;
                    state_d  = ST_DWELL_HI;
                end
            end
            ST_DWELL_HI: begin
                if (!bus.pause) begin
                    if (tmr_zero) state_d = ST_DOWN;
                    else          tmr_dec = 1'b1;
                end
            end
            ST_DOWN: begin
                ctr_en_c = !at_lo && !bus.pause;
                if (at_lo && !bus.pause) begin
                    if (pass_q == reps_q) begin
                        state_d = ST_DONE;
                    end else begin
                        pass_d   = pass_q + NBITS_REP'(1);
                        tmr_load = 1'b1;
                        state_d  = ST_DWELL_LO;
                    end
                end
            end
            ST_DWELL_LO: begin
                if (!bus.pause) begin
                    if (tmr_zero) state_d = ST_UP;
                    else          tmr_dec = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (bus.abort) begin
            state_d    = ST_IDLE;
            err_d      = err_q;
            pass_d     = pass_q;
            latch_cfg  = 1'b0;
            tmr_load   = 1'b0;
            tmr_dec    = 1'b0;
            ctr_load_c = 1'b0;
            ctr_en_c   = 1'b0;
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= bus.start;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    // Configuration is captured only on an accepted start.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            lo_q    <= '0;
            hi_q    <= '0;
            dwell_q <= '0;
            reps_q  <= '0;
        end else if (latch_cfg) begin
            lo_q    <= bus.lo;
            hi_q    <= bus.hi;
            dwell_q <= bus.dwell;
            reps_q  <= bus.reps;
        end
    end

    assign bus.ctr_load = ctr_load_c;
    assign bus.ctr_data = (state_q == ST_LOAD) ? lo_q : '0;
    assign bus.ctr_en   = ctr_en_c;
    assign bus.ctr_up   = ctr_up_c;
    assign bus.busy     = (state_q == ST_LOAD) || (state_q == ST_UP) || (state_q == ST_DWELL_HI) ||
                          (state_q == ST_DOWN) || (state_q == ST_DWELL_LO);
    assign bus.done     = (state_q == ST_DONE) && !bus.abort;
    assign bus.err      = err_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench: per-run expected cycle trace from a pass/dwell model, checked by a negedge monitor.
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    typedef struct {
        logic [2:0] st;
        logic       busy;
        logic       done;
        logic       err;
        logic       load;
        logic       en;
        logic       up;
        logic [3:0] data;
        logic [3:0] count;
        bit         chk;
    } rec_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] cnt_q = 4'd0;

    counter_sequencer_if sif();

    counter_sequencer dut (
        .clk_2 (clk),
        .reset (rst),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    // External counter the sequencer controls.
    assign sif.count = cnt_q;
    always @(posedge clk) begin
        if (sif.ctr_load)    cnt_q <= sif.ctr_data;
        else if (sif.ctr_en) cnt_q <= sif.ctr_up ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end

    rec_t exp_q[$];
    rec_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   mon_cyc = 0;
    bit   sched [0:1023];

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_cyc++;
            checks++;
            if (sif.state !== mon_e.st || sif.busy !== mon_e.busy || sif.done !== mon_e.done ||
                sif.err !== mon_e.err || sif.ctr_load !== mon_e.load || sif.ctr_en !== mon_e.en ||
                sif.ctr_up !== mon_e.up || sif.ctr_data !== mon_e.data ||
                (mon_e.chk && sif.count !== mon_e.count)) begin
                errors++;
                $display("FAIL trace_%0d got st=%0d busy=%b done=%b err=%b load=%b en=%b up=%b data=%0d cnt=%0d expected st=%0d busy=%b done=%b err=%b load=%b en=%b up=%b data=%0d cnt=%0d(chk=%0d)",
                         mon_cyc, sif.state, sif.busy, sif.done, sif.err, sif.ctr_load, sif.ctr_en,
                         sif.ctr_up, sif.ctr_data, sif.count, mon_e.st, mon_e.busy, mon_e.done,
                         mon_e.err, mon_e.load, mon_e.en, mon_e.up, mon_e.data, mon_e.count, mon_e.chk);
            end
        end
    end

    function automatic rec_t mk(input logic [2:0] st, input logic busy, input logic done,
                                input logic err, input logic load, input logic en, input logic up,
                                input logic [3:0] data, input logic [3:0] count, input bit chk);
        rec_t r;
        r.st = st; r.busy = busy; r.done = done; r.err = err; r.load = load;
        r.en = en; r.up = up; r.data = data; r.count = count; r.chk = chk;
        return r;
    endfunction

    // ev: 0 none, 1 abort, 2 reset; evc_in 0 picks a random cycle. mode 0 holds start high, 1 toggles it.
    task automatic run(input int lo, input int hi, input int dw, input int rp, input int ev,
                       input int evc_in, input int pz_lo, input int pz_hi, input int pct, input int mode);
        rec_t       nom[$];
        rec_t       tr[$];
        rec_t       r;
        rec_t       r2;
        int         c;
        int         i;
        int         evc;
        int         active_n;
        logic [3:0] tail_cnt;
        bit         tail_chk;
        logic       tail_err;

        for (int k = 0; k < 1024; k++)
            sched[k] = ((k >= pz_lo) && (k <= pz_hi)) || (int'($urandom_range(99)) < pct);

        evc = evc_in;
        if (lo > hi) begin
            tr.push_back(mk(ST_DONE, 0, 1, 1, 0, 0, 0, 4'd0, 4'd0, 0));
            tail_cnt = 4'd0; tail_chk = 0; tail_err = 1'b1;
            active_n = 1;
        end else begin
            nom.push_back(mk(ST_LOAD, 1, 0, 0, 1, 0, 0, 4'(lo), 4'd0, 0));
            for (int p = 0; p <= rp; p++) begin
                for (int v = lo; v <= hi; v++)
                    nom.push_back(mk(ST_UP, 1, 0, 0, 0, v != hi, 1, 4'd0, 4'(v), 1));
                for (int k = 0; k <= dw; k++)
                    nom.push_back(mk(ST_DWELL_HI, 1, 0, 0, 0, 0, 0, 4'd0, 4'(hi), 1));
                for (int v = hi; v >= lo; v--)
                    nom.push_back(mk(ST_DOWN, 1, 0, 0, 0, v != lo, 0, 4'd0, 4'(v), 1));
                if (p < rp)
                    for (int k = 0; k <= dw; k++)
                        nom.push_back(mk(ST_DWELL_LO, 1, 0, 0, 0, 0, 0, 4'd0, 4'(lo), 1));
            end
            nom.push_back(mk(ST_DONE, 0, 1, 0, 0, 0, 0, 4'd0, 4'(lo), 1));
            if (ev != 0 && evc == 0) evc = int'($urandom_range(nom.size() - 1)) + 1;
            tail_cnt = 4'(lo); tail_chk = 1; tail_err = 1'b0;
            c = 1; i = 0;
            while (i < nom.size()) begin
                r = nom[i];
                if (ev != 0 && c == evc) begin
                    if (ev == 1) begin
                        r.en = 0; r.load = 0; r.done = 0;
                        tr.push_back(r);
                    end else begin
                        r2 = mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 4'd0, r.count, r.chk);
                        tr.push_back(r2);
                        tr.push_back(r2);
                    end
                    tail_cnt = r.count; tail_chk = r.chk;
                    break;
                end
                if (sched[c] && r.st != ST_DONE) begin
                    r.en = 0;
                    tr.push_back(r);
                end else begin
                    tr.push_back(r);
                    i++;
                end
                c++;
            end
            active_n = (ev == 2) ? evc - 1 : tr.size();
        end
        for (int k = 0; k < 3; k++)
            tr.push_back(mk(ST_IDLE, 0, 0, tail_err, 0, 0, 0, 4'd0, tail_cnt, tail_chk));

        sif.lo = 4'(lo); sif.hi = 4'(hi); sif.dwell = 3'(dw); sif.reps = 2'(rp);
        sif.pause = 1'b0; sif.abort = 1'b0; sif.start = 1'b1;
        @(posedge clk); #1;
        foreach (tr[k]) exp_q.push_back(tr[k]);
        for (int cc = 1; cc <= tr.size(); cc++) begin
            sif.pause = sched[cc];
            sif.abort = (ev == 1) && (cc == evc);
            rst       = (ev == 2) && (cc == evc || cc == evc + 1);
            if (ev == 2 && cc > active_n)  sif.start = 1'b0;
            else if (cc <= active_n)        sif.start = (mode == 0) ? 1'b1 : 1'($urandom_range(1));
            sif.lo    = 4'($urandom);
            sif.hi    = 4'($urandom);
            sif.dwell = 3'($urandom);
            sif.reps  = 2'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0; sif.abort = 1'b0; sif.pause = 1'b0; sif.start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int a;
        int b;
        int t;
        int ev;
        int wait_n;
        sif.start = 1'b0; sif.abort = 1'b0; sif.pause = 1'b0;
        sif.lo = 4'd0; sif.hi = 4'd0; sif.dwell = 3'd0; sif.reps = 2'd0;
        rst = 1'b1;
        exp_q.push_back(mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0));
        exp_q.push_back(mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0));
        @(posedge clk); #1;
        checks++;
        if (sif.state !== 3'(ST_IDLE) || sif.busy !== 1'b0 || sif.done !== 1'b0 ||
            sif.err !== 1'b0 || sif.ctr_load !== 1'b0 || sif.ctr_en !== 1'b0 ||
            sif.ctr_up !== 1'b0 || sif.ctr_data !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got st=%0d busy=%b done=%b err=%b load=%b en=%b up=%b data=%0d",
                     sif.state, sif.busy, sif.done, sif.err, sif.ctr_load, sif.ctr_en,
                     sif.ctr_up, sif.ctr_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run(2, 5, 1, 0, 0, 0, 0, -1, 0, 0);
        run(2, 5, 1, 1, 0, 0, 0, -1, 0, 1);
        run(7, 3, 1, 0, 0, 0, 0, -1, 0, 0);
        run(2, 5, 1, 0, 0, 0, 0, -1, 0, 1);
        run(4, 4, 0, 0, 0, 0, 0, -1, 0, 0);
        run(2, 5, 1, 0, 0, 0, 3, 5, 0, 0);
        run(2, 5, 1, 0, 1, 6, 0, -1, 0, 0);
        run(2, 5, 1, 0, 2, 9, 0, -1, 0, 0);
        run(2, 5, 1, 0, 1, 3, 0, -1, 0, 1);

        for (int n = 0; n < 60; n++) begin
            a = int'($urandom_range(15));
            b = int'($urandom_range(15));
            if (a > b && $urandom_range(99) < 85) begin t = a; a = b; b = t; end
            t  = int'($urandom_range(99));
            ev = (t < 80 || a > b) ? 0 : (t < 90 ? 1 : 2);
            run(a, b, int'($urandom_range(7)), int'($urandom_range(3)), ev, 0, 0, -1,
                ($urandom_range(1) == 1) ? 20 : 0, int'($urandom_range(1)));
        end

        wait_n = 0;
        while (exp_q.size() > 0 && wait_n < 64) begin
            @(posedge clk); #1;
            wait_n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wait_expired trace entries left=%0d after %0d cycles", exp_q.size(), wait_n);
        end

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
